bnn_sram_port_arbiter: RTL

//  Shares one single-port 4096x16 input/output SRAM among N_REQ requesters.

---
 rtl/bnn_mem_pkg.sv | 17 +
 rtl/bnn_sram_port_arbiter_rr_pick.sv | 27 ++
 rtl/bnn_sram_port_arbiter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/bnn_mem_pkg.sv
// Shared memory-map constants and arbiter types for the BNN input/output SRAM.
// Reused by the conv engine, the image loader and the SRAM port arbiter.
package bnn_mem_pkg;

  localparam int SRAM_AW    = 12;
  localparam int SRAM_DW    = 16;
  localparam int SRAM_DEPTH = 4096;

  // Burst counter width; holds MAX_BURST values up to 15.
  localparam int BURST_W = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bnn_sram_port_arbiter_rr_pick.sv
// Rotating-priority encoder: returns the first set request bit at or after
// the start pointer, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [IW-1:0]    idx,
  output logic             any
);

  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(start) + k) % N_REQ;
      if (!any && req[j]) begin
        any = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bnn_sram_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N_REQ requesters,
// with sticky ownership capped at MAX_BURST grants while others wait.
module bnn_sram_port_arbiter
  import bnn_mem_pkg::*;
#(
  parameter int N_REQ     = 3,
  parameter int AW        = SRAM_AW,
  parameter int DW        = SRAM_DW,
  parameter int MAX_BURST = 4
) (
  input  logic                clk,
  input  logic                reset_b,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ-1:0]    we_i,
  input  logic [N_REQ*AW-1:0] addr_i,
  input  logic [N_REQ*DW-1:0] wdata_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [N_REQ-1:0]    rvalid_o,
  output logic [DW-1:0]       rdata_o,
  output logic                sram_en_o,
  output logic                sram_we_o,
  output logic [AW-1:0]       sram_addr_o,
  output logic [DW-1:0]       sram_wdata_o,
  input  logic [DW-1:0]       sram_rdata_i
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e         state, state_nxt;
  logic [IW-1:0]      owner, rr_ptr;
  logic [BURST_W-1:0] burst_cnt;
  logic               own_valid;
  logic [N_REQ-1:0]   owner_oh;
  logic               other_req, sticky;
  logic               rr_any, win_any;
  logic [IW-1:0]      rr_idx, win;

  function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] c);
    if (c >= BURST_W'(MAX_BURST)) return BURST_W'(MAX_BURST);
    return c + BURST_W'(1);
  endfunction

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    if (int'(i) == N_REQ - 1) return '0;
    return i + IW'(1);
  endfunction

  assign own_valid = (state == ARB_OWN);
  assign owner_oh  = N_REQ'(1) << owner;
  assign other_req = |(req_i & ~owner_oh);

  // The owner keeps the port until its burst is spent, unless nobody else wants it.
  assign sticky = own_valid && (|(req_i & owner_oh)) &&
                  ((burst_cnt < BURST_W'(MAX_BURST)) || !other_req);

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req   (req_i),
    .start (rr_ptr),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign win_any = sticky || rr_any;
  assign win     = sticky ? owner : rr_idx;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= ARB_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = win_any ? ARB_OWN : ARB_IDLE;
  end

  always_comb begin
    gnt_o        = '0;
    sram_en_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_any && (win == IW'(i))) begin
        gnt_o[i]     = 1'b1;
        sram_en_o    = 1'b1;
        sram_we_o    = we_i[i];
        sram_addr_o  = addr_i[i*AW +: AW];
        sram_wdata_o = wdata_i[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (win_any) begin
      if (own_valid && (win == owner)) begin
        burst_cnt <= sat_inc(burst_cnt);
      end else begin
        owner     <= win;
        burst_cnt <= BURST_W'(1);
        rr_ptr    <= wrap_inc(win);
      end
    end else begin
      burst_cnt <= '0;
    end
  end

  // ---- read return stage: SRAM data arrives one cycle after the access ----
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) rvalid_o <= '0;
    else          rvalid_o <= (sram_en_o && !sram_we_o) ? gnt_o : '0;
  end

  assign rdata_o = sram_rdata_i;

endmodule
